// File: rtl/cpsr_write_ctrl.sv
// CPSR write sequencer: arbitrates flag updates, MSR writes, exception entry and
// exception return onto the CPSR field-load code (ld) and data (din); holds spsr.
module cpsr_write_ctrl #(
   parameter logic [31:0] SPSR_RESET = 32'h0000_0000,
   parameter int          MSR_ENABLE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cpsr_q,
   input  logic        flags_valid,
   input  logic [3:0]  flags,
   output logic        flags_ready,
   input  logic        msr_valid,
   input  logic [2:0]  msr_mask,
   input  logic [31:0] msr_data,
   output logic        msr_ready,
   output logic        msr_err,
   input  logic        exc_req,
   input  logic [5:0]  exc_mode,
   output logic        exc_ack,
   input  logic        rfe_req,
   output logic        rfe_ready,
   output logic [2:0]  ld,
   output logic [31:0] din,
   output logic [31:0] spsr,
   output logic        busy
);

   // Handshake: a request is accepted on the rising edge where its valid and
   // ready are both 1; a requester that sees ready=0 keeps valid and its data stable.

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAVE   = 2'd1,
      SWITCH = 2'd2
   } state_t;

   localparam logic MSR_EN = (MSR_ENABLE != 0);

   state_t      state, state_d;
   logic [2:0]  ld_d;
   logic [31:0] din_d;
   logic [31:0] spsr_d;
   logic        ack_d;
   logic        err_d;

   logic idle;
   logic exc_pend;
   logic rfe_acc;
   logic msr_acc;
   logic flags_acc;
   logic mask_legal;

   assign idle = (state == IDLE);
   // exc_req is still held during its ack cycle; it must not restart entry.
   assign exc_pend = exc_req && !exc_ack;

   assign rfe_ready   = idle && !exc_pend;
   assign msr_ready   = idle && !exc_pend && !rfe_req && MSR_EN;
   assign flags_ready = idle && !exc_pend && !rfe_req && !(msr_valid && MSR_EN);
   assign busy        = !idle;

   assign rfe_acc   = rfe_req && rfe_ready;
   assign msr_acc   = msr_valid && msr_ready;
   assign flags_acc = flags_valid && flags_ready;

   assign mask_legal = (msr_mask == 3'b001) || (msr_mask == 3'b010) ||
                       (msr_mask == 3'b100) || (msr_mask == 3'b111);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ld      <= 3'b000;
         din     <= 32'h0;
         spsr    <= SPSR_RESET;
         exc_ack <= 1'b0;
         msr_err <= 1'b0;
      end else begin
         state   <= state_d;
         ld      <= ld_d;
         din     <= din_d;
         spsr    <= spsr_d;
         exc_ack <= ack_d;
         msr_err <= err_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (exc_pend) state_d = SAVE;
         SAVE:    state_d = SWITCH;
         SWITCH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ld_d   = 3'b000;
      din_d  = din;
      spsr_d = spsr;
      ack_d  = 1'b0;
      err_d  = 1'b0;
      case (state)
         IDLE: begin
            // Entry leaves ld idle for one cycle so a write issued last cycle lands first.
            if (rfe_acc) begin
               ld_d  = 3'b111;
               din_d = spsr;
            end else if (msr_acc) begin
               if (mask_legal) begin
                  ld_d  = msr_mask;
                  din_d = msr_data;
               end else begin
                  err_d = 1'b1;
               end
            end else if (flags_acc) begin
               ld_d  = 3'b001;
               din_d = {cpsr_q[31:10], flags, cpsr_q[5:0]};
            end
         end
         SAVE: begin
            spsr_d = cpsr_q;
            ld_d   = 3'b010;
            din_d  = {cpsr_q[31:6], exc_mode};
         end
         SWITCH: begin
            ack_d = 1'b1;
         end
         default: begin
            ld_d = 3'b000;
         end
      endcase
   end

endmodule
